// File: rtl/arb_mux_rr.sv
// N-way WIDTH-bit registered selector with valid/ready handshake and round-robin or
// fixed-priority arbitration. Optional forced selection via `define ARB_MUX_FORCE_SEL_EN.
module arb_mux_rr #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned N       = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned RR_MODE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  input  logic               out_ready
`ifdef ARB_MUX_FORCE_SEL_EN
  ,
  input  logic               force_en,
  input  logic [SEL_W-1:0]   force_sel
`endif
);

  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SEL_W-1:0]   out_src_q;
  logic [SEL_W-1:0]   rr_ptr_q;
  logic [SEL_W-1:0]   rr_ptr_d;

  logic               load_en;
  logic               grant_any;
  logic [SEL_W-1:0]   grant_idx;
  logic [N-1:0]       grant;
  logic [WIDTH-1:0]   sel_data;
  logic               transfer;
  logic               ptr_upd_en;

  assign load_en = !out_valid_q || out_ready;

  // Scan from rr_ptr (round-robin) or from 0 (fixed priority); first requester wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = k;
      if (RR_MODE != 0) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
      end
      if (!grant_any && in_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
`ifdef ARB_MUX_FORCE_SEL_EN
    // Forced selection bypasses arbitration; an out-of-range index grants nothing.
    if (force_en) begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (force_sel == SEL_W'(i) && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
`endif
  end

  always_comb begin
    grant    = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      grant[i] = grant_any && (grant_idx == SEL_W'(i));
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready = load_en ? grant : '0;
  assign transfer = load_en && grant_any;

`ifdef ARB_MUX_FORCE_SEL_EN
  assign ptr_upd_en = transfer && !force_en;
`else
  assign ptr_upd_en = transfer;
`endif

  // Wrap explicitly so a non-power-of-2 N never reaches indices >= N.
  assign rr_ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      if (load_en) out_valid_q <= transfer;
      if (transfer) begin
        out_data_q <= sel_data;
        out_src_q  <= grant_idx;
      end
      if (ptr_upd_en) rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
